// File: rtl/binarize_pkg.sv
// Shared types and constants for the binarize pipeline.
// Holds pixel/channel widths, black/white pixels, default luma weights.
package binarize_pkg;

   localparam int PIX_W  = 24;
   localparam int CH_W   = 8;
   localparam int PROD_W = 2 * CH_W;
   localparam int SUM_W  = PROD_W + 2;

   localparam logic [PIX_W-1:0] PIX_WHITE = 24'hFFFFFF;
   localparam logic [PIX_W-1:0] PIX_BLACK = 24'h000000;

   localparam int R_COEF_DEF = 77;
   localparam int G_COEF_DEF = 150;
   localparam int B_COEF_DEF = 29;

   typedef logic [CH_W-1:0]   chan_t;
   typedef logic [PROD_W-1:0] prod_t;

   typedef struct packed {
      prod_t r;
      prod_t g;
      prod_t b;
      logic  de;
      logic  hsync;
      logic  vsync;
      logic  invert;
   } s1_t;

   typedef struct packed {
      chan_t y;
      logic  de;
      logic  hsync;
      logic  vsync;
      logic  invert;
   } s2_t;

   function automatic prod_t weigh(chan_t c, int coef);
      return prod_t'(c) * prod_t'(coef);
   endfunction

endpackage

// File: rtl/binarize_minmax.sv
// Per-frame min/max tracker of luma; sets threshold at frame boundaries.
// Ports: clk, rst_n (sync, active low), y/de/vsync (stage-2 aligned), thr.
module binarize_minmax
   import binarize_pkg::*;
#(
   parameter int RESET_THR = 128
) (
   input  logic  clk,
   input  logic  rst_n,
   input  chan_t y,
   input  logic  de,
   input  logic  vsync,
   output chan_t thr
);

   chan_t         min_q;
   chan_t         max_q;
   logic          seen_q;
   logic          vs_q;
   logic          frame_edge;
   logic [CH_W:0] mid;

   always_comb begin
      frame_edge = vsync & ~vs_q;
      // 9-bit sum so the midpoint cannot overflow
      mid        = {1'b0, min_q} + {1'b0, max_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         min_q  <= '1;
         max_q  <= '0;
         seen_q <= 1'b0;
         vs_q   <= 1'b0;
         thr    <= CH_W'(RESET_THR);
      end else begin
         vs_q <= vsync;
         if (frame_edge) begin
            // Empty frame keeps the old threshold.
            if (seen_q)
               thr <= CH_W'(mid >> 1);
            // A pixel on the edge cycle opens the new frame.
            min_q  <= de ? y : '1;
            max_q  <= de ? y : '0;
            seen_q <= de;
         end else if (de) begin
            if (y < min_q)
               min_q <= y;
            if (y > max_q)
               max_q <= y;
            seen_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/binarize.sv
// Three-stage luma threshold: weigh channels, sum to Y, compare to thr.
// Ports: clk, rst_n (sync, active low), pixel/de/hsync/vsync in and out,
// thr_in, invert, thr_active. Define BINARIZE_AUTO_THRESH_EN for
// per-frame automatic threshold (thr_in is then ignored).
module binarize
   import binarize_pkg::*;
#(
   parameter int R_COEF    = R_COEF_DEF,
   parameter int G_COEF    = G_COEF_DEF,
   parameter int B_COEF    = B_COEF_DEF,
   parameter int RESET_THR = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic             de_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic [CH_W-1:0]  thr_in,
   input  logic             invert,
   output logic [PIX_W-1:0] pixel_out,
   output logic             de_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [CH_W-1:0]  thr_active
);

   s1_t              s1_q;
   s2_t              s2_q;
   logic [SUM_W-1:0] sum;
   logic             white;

   always_comb begin
      sum   = SUM_W'(s1_q.r) + SUM_W'(s1_q.g) + SUM_W'(s1_q.b);
      white = (s2_q.y >= thr_active) ^ s2_q.invert;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         pixel_out <= PIX_BLACK;
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         s1_q.r      <= weigh(pixel_in[23:16], R_COEF);
         s1_q.g      <= weigh(pixel_in[15:8], G_COEF);
         s1_q.b      <= weigh(pixel_in[7:0], B_COEF);
         s1_q.de     <= de_in;
         s1_q.hsync  <= hsync_in;
         s1_q.vsync  <= vsync_in;
         s1_q.invert <= invert;

         // Weights sum to 256, so Y is the sum's middle byte.
         s2_q.y      <= CH_W'(sum >> 8);
         s2_q.de     <= s1_q.de;
         s2_q.hsync  <= s1_q.hsync;
         s2_q.vsync  <= s1_q.vsync;
         s2_q.invert <= s1_q.invert;

         // Blanking is always black, even when inverted.
         pixel_out <= (s2_q.de && white) ? PIX_WHITE : PIX_BLACK;
         de_out    <= s2_q.de;
         hsync_out <= s2_q.hsync;
         vsync_out <= s2_q.vsync;
      end
   end

`ifdef BINARIZE_AUTO_THRESH_EN
   logic thr_unused;
   assign thr_unused = ^thr_in;

   binarize_minmax #(
      .RESET_THR (RESET_THR)
   ) u_minmax (
      .clk   (clk),
      .rst_n (rst_n),
      .y     (s2_q.y),
      .de    (s2_q.de),
      .vsync (s2_q.vsync),
      .thr   (thr_active)
   );
`else
   always_ff @(posedge clk) begin
      if (!rst_n)
         thr_active <= CH_W'(RESET_THR);
      else
         thr_active <= thr_in;
   end
`endif

endmodule

// File: tb/tb_binarize.sv
// Directed self-checking bench for binarize.
// Covers reset, manual/inverted compare, alignment, mid-frame reset, auto.
module tb_binarize;
   import binarize_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] pixel_in = '0;
   logic        de_in = 1'b0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic [7:0]  thr_in = 8'd100;
   logic        invert = 1'b0;
   logic [23:0] pixel_out;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic [7:0]  thr_active;

   int n_chk = 0;
   int n_err = 0;

   logic        h_de [32];
   logic        h_hs [32];
   logic        h_vs [32];

   binarize dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixel_in   (pixel_in),
      .de_in      (de_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .thr_in     (thr_in),
      .invert     (invert),
      .pixel_out  (pixel_out),
      .de_out     (de_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .thr_active (thr_active)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_check(string tag, logic [23:0] p, logic de,
                             logic inv, logic [23:0] exp);
      pixel_in = p;
      de_in    = de;
      invert   = inv;
      tick();
      pixel_in = '0;
      de_in    = 1'b0;
      invert   = 1'b0;
      tick();
      chk({tag, "_early"}, {8'h0, pixel_out}, 32'h0);
      tick();
      chk(tag, {8'h0, pixel_out}, {8'h0, exp});
      chk({tag, "_de"}, {31'h0, de_out}, {31'h0, de});
   endtask

   initial begin
      // Reset with busy inputs: outputs stay cleared, thr at reset value.
      pixel_in = 24'hFFFFFF;
      de_in    = 1'b1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      tick();
      tick();
      tick();
      chk("rst_pix", {8'h0, pixel_out}, 32'h0);
      chk("rst_de", {31'h0, de_out}, 32'h0);
      chk("rst_hs", {31'h0, hsync_out}, 32'h0);
      chk("rst_vs", {31'h0, vsync_out}, 32'h0);
      chk("rst_thr", {24'h0, thr_active}, 32'd128);

      pixel_in = '0;
      de_in    = 1'b0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      thr_in   = 8'd128;
      rst_n    = 1'b1;
      tick();
      chk("thr_after_rst", {24'h0, thr_active}, 32'd128);
      tick();
      tick();

      send_check("y128", 24'h808080, 1'b1, 1'b0, 24'hFFFFFF);
      send_check("y127", 24'h7F7F7F, 1'b1, 1'b0, 24'h000000);
      send_check("inv_white", 24'hFFFFFF, 1'b1, 1'b1, 24'h000000);
      send_check("inv_black", 24'h000000, 1'b1, 1'b1, 24'hFFFFFF);
      send_check("blank_inv", 24'hFFFFFF, 1'b0, 1'b1, 24'h000000);
      send_check("blank", 24'hFFFFFF, 1'b0, 1'b0, 24'h000000);
      send_check("red_128", 24'hFF0000, 1'b1, 1'b0, 24'h000000);
      send_check("green_128", 24'h00FF00, 1'b1, 1'b0, 24'hFFFFFF);

`ifndef BINARIZE_AUTO_THRESH_EN
      // Red 255 gives Y=76; probe both sides of that threshold.
      thr_in = 8'd76;
      chk("thr_delay", {24'h0, thr_active}, 32'd128);
      tick();
      chk("thr_76", {24'h0, thr_active}, 32'd76);
      send_check("red_76", 24'hFF0000, 1'b1, 1'b0, 24'hFFFFFF);
      thr_in = 8'd77;
      tick();
      send_check("red_77", 24'hFF0000, 1'b1, 1'b0, 24'h000000);
      send_check("blue_77", 24'h0000FF, 1'b1, 1'b0, 24'h000000);
      thr_in = 8'd128;
      tick();
`endif

      // Sync/de alignment with random pixels.
      for (int i = 0; i < 24; i++) begin
         pixel_in = 24'($urandom);
         de_in    = 1'($urandom);
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
         h_de[i]  = de_in;
         h_hs[i]  = hsync_in;
         h_vs[i]  = vsync_in;
         tick();
         if (i >= 2) begin
            chk("align_de", {31'h0, de_out}, {31'h0, h_de[i-2]});
            chk("align_hs", {31'h0, hsync_out}, {31'h0, h_hs[i-2]});
            chk("align_vs", {31'h0, vsync_out}, {31'h0, h_vs[i-2]});
            if (!h_de[i-2])
               chk("align_blank", {8'h0, pixel_out}, 32'h0);
         end
      end
      pixel_in = '0;
      de_in    = 1'b0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      tick();
      tick();
      tick();

      // Mid-frame reset discards pixels in flight.
      pixel_in = 24'h808080;
      de_in    = 1'b1;
      hsync_in = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("mrst_pix", {8'h0, pixel_out}, 32'h0);
      chk("mrst_de", {31'h0, de_out}, 32'h0);
      chk("mrst_hs", {31'h0, hsync_out}, 32'h0);
      chk("mrst_thr", {24'h0, thr_active}, 32'd128);
      rst_n    = 1'b1;
      pixel_in = '0;
      de_in    = 1'b0;
      hsync_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mrst_flush", {31'h0, de_out}, 32'h0);
      end
      send_check("post_rst", 24'h808080, 1'b1, 1'b0, 24'hFFFFFF);

`ifdef BINARIZE_AUTO_THRESH_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      // Frame with no valid pixels leaves threshold alone.
      vsync_in = 1'b1;
      tick();
      tick();
      vsync_in = 1'b0;
      for (int i = 0; i < 5; i++)
         tick();
      chk("auto_empty", {24'h0, thr_active}, 32'd128);
      // Frame holding Y=40 and Y=200 only.
      pixel_in = 24'h282828;
      de_in    = 1'b1;
      tick();
      pixel_in = 24'hC8C8C8;
      tick();
      pixel_in = '0;
      de_in    = 1'b0;
      tick();
      tick();
      tick();
      chk("auto_midframe", {24'h0, thr_active}, 32'd128);
      vsync_in = 1'b1;
      tick();
      tick();
      chk("auto_pre_edge", {24'h0, thr_active}, 32'd128);
      tick();
      tick();
      vsync_in = 1'b0;
      chk("auto_thr", {24'h0, thr_active}, 32'd120);
      tick();
      send_check("auto_y119", 24'h777777, 1'b1, 1'b0, 24'h000000);
      send_check("auto_y120", 24'h787878, 1'b1, 1'b0, 24'hFFFFFF);
      chk("auto_thr_hold", {24'h0, thr_active}, 32'd120);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/binarize.md
BINARIZE -- requirements
Module: binarize

Interface
REQ-001 Parameter R_COEF, default 77: red luma weight.
REQ-002 Parameter G_COEF, default 150: green luma weight.
REQ-003 Parameter B_COEF, default 29: blue luma weight; R_COEF+G_COEF+B_COEF SHALL equal 256.
REQ-004 Parameter RESET_THR, default 128: threshold value loaded at reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 pixel_in  input  24  pixel, [23:16]=R, [15:8]=G, [7:0]=B.
REQ-008 de_in  input  1  data enable; pixel_in valid when high.
REQ-009 hsync_in  input  1  horizontal sync, passed through.
REQ-010 vsync_in  input  1  vertical sync, passed through; rising edge marks frame boundary.
REQ-011 thr_in  input  8  manual threshold.
REQ-012 invert  input  1  when high, swaps black/white output.
REQ-013 pixel_out  output  24  binarized pixel, 24'hFFFFFF or 24'h000000.
REQ-014 de_out, hsync_out, vsync_out  output  1 each  sync outputs delayed to match pixel_out.
REQ-015 thr_active  output  8  threshold applied in the compare stage.

Function
REQ-016 Stage 1 SHALL register R*R_COEF, G*G_COEF, B*B_COEF (16 bits each) and the sync/de inputs.
REQ-017 Stage 2 SHALL register Y = (sum of stage-1 products) >> 8, 8 bits, sum held at 18 bits with no overflow.
REQ-018 Stage 3 SHALL register pixel_out = 24'hFFFFFF when (Y >= thr_active) XOR invert_d, else 24'h000000.
REQ-019 When stage-3 de is low, pixel_out SHALL be 24'h000000 regardless of invert.
REQ-020 Latency from any input to the corresponding output SHALL be exactly 3 cycles, including de/hsync/vsync.
REQ-021 invert SHALL be delayed 2 cycles so it aligns with the pixel it qualifies.
REQ-022 Block SHALL accept one pixel per cycle with no backpressure and no stall.

Reset
REQ-023 While rst_n is low at a clock edge: pixel_out=0, de_out=0, hsync_out=0, vsync_out=0, all pipeline registers 0, thr_active=RESET_THR.
REQ-024 Reset asserted mid-frame SHALL discard in-flight pixels; first valid output appears 3 cycles after the first de_in high after release.
REQ-025 After reset in auto mode, min/max trackers SHALL be at their cleared values (min=8'hFF, max=8'h00, seen=0).

Configuration
REQ-026 Macro BINARIZE_AUTO_THRESH_EN selects automatic thresholding.
REQ-027 Without macro: thr_active SHALL register thr_in every cycle (1-cycle delay); no min/max logic synthesized.
REQ-028 With macro: thr_in SHALL be ignored; block SHALL track min and max of stage-2 Y over stage-2-aligned de-high cycles.
REQ-029 With macro: on rising edge of stage-2-aligned vsync, if seen=1, thr_active SHALL load (min+max)>>1 computed at 9 bits; if seen=0, thr_active SHALL be held.
REQ-030 With macro: on that same edge, trackers SHALL clear; a valid pixel in the edge cycle SHALL count toward the new frame.
REQ-031 With macro: thr_active SHALL change only at frame boundaries, never mid-frame.

Structure
REQ-032 Shared package SHALL hold pixel width (24), channel width (8), white/black pixel constants and default luma coefficients.
REQ-033 One sub-module, binarize_minmax, SHALL contain the min/max trackers and threshold update; instantiated only under BINARIZE_AUTO_THRESH_EN.

Verification
REQ-034 Manual: thr_in=128, pixel_in=24'h808080, de_in=1 -> pixel_out=24'hFFFFFF 3 cycles later; pixel_in=24'h7F7F7F -> 24'h000000.
REQ-035 Invert: thr_in=128, invert=1, pixel_in=24'hFFFFFF -> pixel_out=24'h000000; de_in=0 -> pixel_out=0 regardless.
REQ-036 Alignment: toggle hsync_in/vsync_in/de_in with random pixels -> each output equals its input delayed exactly 3 cycles.
REQ-037 Auto: frame with Y values 40 and 200 only, then vsync rising -> thr_active=120 from that boundary; next frame pixel Y=119 -> black, Y=120 -> white.
REQ-038 Auto: frame with de_in never high, then vsync edge -> thr_active unchanged (128 after reset).
REQ-039 Reset mid-frame: assert rst_n=0 for 1 cycle during active pixels -> all outputs 0 next cycle, thr_active=128.
